// File: rtl/store_monitor.sv
// Store monitor for the single-cycle computer's data-memory write port:
// logs stores into a FWFT FIFO and decides pass/fail/timeout on WATCH_ADDR.
module store_monitor #(
  parameter int unsigned   n          = 32,
  parameter int unsigned   DEPTH      = 8,
  parameter logic [n-1:0]  WATCH_ADDR = 84,
  parameter logic [n-1:0]  EXPECT     = 32'h96,
  parameter int unsigned   TIMEOUT    = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     memwrite,
  input  logic [n-1:0]             dataadr,
  input  logic [n-1:0]             writedata,
  input  logic                     log_ready,
  output logic                     log_valid,
  output logic [n-1:0]             log_addr,
  output logic [n-1:0]             log_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q;
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     cnt_q;
  logic            ovf_q, to_q;
  logic [n-1:0]    mem_a [DEPTH];
  logic [n-1:0]    mem_d [DEPTH];

  logic active, capture, watch_hit, term, full, pop, push;

  assign active    = (state_q == S_RUN) && enable;
  assign capture   = active && memwrite;
  assign watch_hit = capture && (dataadr == WATCH_ADDR);
  assign term      = active && (cyc_q == CW'(TIMEOUT - 1));
  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign pop       = log_valid && log_ready;
  // A full FIFO still accepts the store when the head leaves on the same edge.
  assign push      = capture && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (active && (cyc_q != CW'(TIMEOUT - 1)))
        cyc_q <= cyc_q + CW'(1);
      if (term && !watch_hit)
        to_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_RUN;
      S_RUN: begin
        if (!enable)        state_d = S_IDLE;
        else if (watch_hit) state_d = (writedata == EXPECT) ? S_PASS : S_FAIL;
        else if (term)      state_d = S_FAIL;
      end
      default: ;
    endcase
  end

  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    unique case (state_q)
      S_PASS:  begin done = 1'b1; pass = 1'b1; end
      S_FAIL:  begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_q <= cnt_q - (AW+1)'(1);
      if (capture && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wp_q] <= dataadr;
      mem_d[wp_q] <= writedata;
    end
  end

  assign log_valid = (cnt_q != '0);
  assign log_addr  = mem_a[rp_q];
  assign log_data  = mem_d[rp_q];
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_store_monitor.sv
// Bench for store_monitor: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_store_monitor;

  localparam int unsigned N  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned TO = 48;
  localparam logic [31:0] WA = 84;
  localparam logic [31:0] EX = 32'h96;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          memwrite = 1'b0;
  logic [N-1:0]  dataadr = '0;
  logic [N-1:0]  writedata = '0;
  logic          log_ready = 1'b0;
  logic          log_valid;
  logic [N-1:0]  log_addr, log_data;
  logic [$clog2(D):0] count;
  logic          overflow, done, pass, fail, timeout;

  store_monitor #(.n(N), .DEPTH(D), .WATCH_ADDR(WA), .EXPECT(EX), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .log_ready(log_ready),
    .log_valid(log_valid), .log_addr(log_addr), .log_data(log_data),
    .count(count), .overflow(overflow), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a monitor is "armed" while running; verdict flags are sticky.
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit m_armed, m_done, m_pass, m_fail, m_to, m_ovf;
  int m_cycles;

  task automatic model_clear();
    q.delete();
    m_armed = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_ovf = 0;
    m_cycles = 0;
  endtask

  task automatic model_edge();
    bit popping, pushing, decided;
    ent_t e;
    popping = (q.size() > 0) && log_ready;
    pushing = 0;
    decided = 0;
    if (m_armed && !m_done && enable) begin
      if (memwrite) begin
        if (q.size() < D || popping) pushing = 1;
        else m_ovf = 1;
        if (dataadr == WA) begin
          decided = 1;
          m_done = 1;
          if (writedata == EX) m_pass = 1; else m_fail = 1;
        end
      end
      if (!decided && m_cycles == TO - 1) begin
        m_done = 1; m_fail = 1; m_to = 1;
      end
      m_cycles++;
    end
    if (popping) void'(q.pop_front());
    if (pushing) begin
      e.a = dataadr;
      e.d = writedata;
      q.push_back(e);
    end
    if (!m_done) m_armed = enable;
  endtask

  task automatic compare_all();
    check_eq("count", count, q.size());
    check_eq("log_valid", log_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("head_addr", log_addr, q[0].a);
      check_eq("head_data", log_data, q[0].d);
    end
    check_eq("overflow", overflow, m_ovf);
    check_eq("done", done, m_done);
    check_eq("pass", pass, m_pass);
    check_eq("fail", fail, m_fail);
    check_eq("timeout", timeout, m_to);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0; memwrite = 1'b0; log_ready = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  initial begin
    int steps;

    do_reset();

    // Matching watch store gives a pass one edge later.
    enable = 1'b1; step();
    store(WA, EX);
    check_eq("t1_pass", pass, 1'b1);
    check_eq("t1_addr", log_addr, 32'd84);
    check_eq("t1_data", log_data, 32'h96);
    check_eq("t1_count", count, 1);

    // Mismatching watch store fails; later stores are ignored.
    do_reset();
    enable = 1'b1; step();
    store(WA, 32'h95);
    check_eq("t2_fail", fail, 1'b1);
    check_eq("t2_timeout", timeout, 1'b0);
    store(WA, EX);
    check_eq("t2_pass", pass, 1'b0);
    check_eq("t2_count", count, 1);

    // Timeout with no stores: entry edge plus TO edges in RUN.
    do_reset();
    enable = 1'b1;
    steps = 0;
    while (!done && steps < 4 * TO) begin step(); steps++; end
    check_eq("t3_to_edges", steps, TO + 1);
    check_eq("t3_timeout", timeout, 1'b1);

    // Timeout with a 5-cycle enable gap after 8 RUN edges.
    do_reset();
    enable = 1'b1;
    step();
    repeat (8) step();
    enable = 1'b0;
    repeat (5) step();
    enable = 1'b1;
    steps = 14;
    while (!done && steps < 4 * TO) begin step(); steps++; end
    check_eq("t3_gap_edges", steps, TO + 7);

    // Overflow: 10 stores into 8 entries, then drain in order.
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 10; i++) store(i, $urandom);
    check_eq("t4_count", count, D);
    check_eq("t4_ovf", overflow, 1'b1);
    log_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("t4_drain", log_addr, i);
      step();
    end
    log_ready = 1'b0;
    check_eq("t4_empty", log_valid, 1'b0);

    // Full FIFO with simultaneous push and pop, sustained across pointer wrap.
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 8; i++) store(i, $urandom);
    log_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      store(100 + i, $urandom);
      check_eq("t5_count", count, D);
      check_eq("t5_ovf", overflow, 1'b0);
    end
    check_eq("t5_head", log_addr, 32'd112);
    repeat (10) step();
    log_ready = 1'b0;

    // Asynchronous reset with entries queued, then IDLE until enabled.
    do_reset();
    enable = 1'b1; step();
    for (int i = 0; i < 3; i++) store(40 + i, $urandom);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_count", count, 0);
    check_eq("t6_valid", log_valid, 1'b0);
    check_eq("t6_done", done, 1'b0);
    model_clear();
    compare_all();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    memwrite = 1'b1; dataadr = WA; writedata = EX;
    repeat (3) step();
    check_eq("t6_idle_count", count, 0);
    enable = 1'b1;
    repeat (2) step();
    check_eq("t6_pass", pass, 1'b1);
    memwrite = 1'b0;

    // Randomized episodes.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 70; c++) begin
        enable    = ($urandom_range(0, 9) != 0);
        memwrite  = $urandom_range(0, 1);
        dataadr   = ($urandom_range(0, 14) == 0) ? WA : 32'($urandom_range(0, 40) * 4);
        writedata = $urandom_range(0, 1) ? EX : $urandom;
        log_ready = ($urandom_range(0, 2) == 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
